gpio_bank_arbiter: RTL and testbench

- Shares one NUM_GPIO-wide GPIO pad bank between two GPIO controllers: requester 0 is the host APB GPIO and requester 1 is the secondary/secure-domain GPIO.
- Sits between the GPIO controllers and the gpio2padframe adapter, and drives that adapter's gpio_out/gpio_dir/gpio_in.
- Grants exclusive bank ownership with a request/grant handshake and round-robin arbitration.
- Every ownership handover passes through a TURN_CYCLES-long all-tristate turnaround, so no pad is driven by two owners back-to-back.

---
 rtl/gpio_bank_arbiter.sv | 155 +++++++++++++++
 tb/tb_gpio_bank_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_arbiter.sv
// Round-robin owner arbiter for one shared GPIO pad bank with two controllers.
// Every handover passes through an all-tristate turnaround so no pad sees two drivers.
module gpio_bank_arbiter #(
  parameter int NUM_GPIO    = 64,
  parameter int TURN_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_i,
  output logic [1:0]          gnt_o,
  input  logic [NUM_GPIO-1:0] r0_gpio_out_i,
  input  logic [NUM_GPIO-1:0] r0_gpio_dir_i,
  output logic [NUM_GPIO-1:0] r0_gpio_in_o,
  input  logic [NUM_GPIO-1:0] r1_gpio_out_i,
  input  logic [NUM_GPIO-1:0] r1_gpio_dir_i,
  output logic [NUM_GPIO-1:0] r1_gpio_in_o,
  output logic [NUM_GPIO-1:0] gpio_out_o,
  output logic [NUM_GPIO-1:0] gpio_dir_o,
  input  logic [NUM_GPIO-1:0] gpio_in_i,
  output logic                turn_o,
  output logic [1:0]          owner_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_e;

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       win_valid;
  logic       win_id;

  // On contention the requester that did not own the bank last time wins.
  always_comb begin
    win_valid = (req_i != 2'b00);
    win_id    = 1'b0;
    case (req_i)
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_owner_q;
      default: win_id = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d      = win_id ? OWN1 : OWN0;
          last_owner_d = win_id;
        end
      end
      OWN0: begin
        if (!req_i[0]) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      OWN1: begin
        if (!req_i[1]) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      TURN: begin
        if (cnt_q == 8'd0) begin
          if (win_valid) begin
            state_d      = win_id ? OWN1 : OWN0;
            last_owner_d = win_id;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Status and pad routing decode from the state register only; data is a zero-latency mux.
  always_comb begin
    gnt_o        = 2'b00;
    owner_o      = 2'b00;
    turn_o       = 1'b0;
    gpio_out_o   = '0;
    gpio_dir_o   = '0;
    r0_gpio_in_o = '0;
    r1_gpio_in_o = '0;
    case (state_q)
      OWN0: begin
        gnt_o        = 2'b01;
        owner_o      = 2'b01;
        gpio_out_o   = r0_gpio_out_i;
        gpio_dir_o   = r0_gpio_dir_i;
        r0_gpio_in_o = gpio_in_i;
      end
      OWN1: begin
        gnt_o        = 2'b10;
        owner_o      = 2'b10;
        gpio_out_o   = r1_gpio_out_i;
        gpio_dir_o   = r1_gpio_dir_i;
        r1_gpio_in_o = gpio_in_i;
      end
      TURN:    turn_o = 1'b1;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  logic [8:0] gap_q;
  logic       had_gnt_q;
  logic [1:0] gnt_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q      <= 9'd0;
      had_gnt_q  <= 1'b0;
      gnt_prev_q <= 2'b00;
    end else begin
      gnt_prev_q <= gnt_o;
      if (gnt_o == 2'b00) begin
        if (gap_q != 9'h1ff) gap_q <= gap_q + 9'd1;
      end else begin
        gap_q     <= 9'd0;
        had_gnt_q <= 1'b1;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) gnt_o != 2'b11);
  a_idle_tristate: assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_o == 2'b00) |-> (gpio_dir_o == '0));
  a_no_direct_switch: assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_o != 2'b00 && gnt_prev_q != 2'b00) |-> (gnt_o == gnt_prev_q));
  a_turn_gap: assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_o != 2'b00 && gnt_prev_q == 2'b00 && had_gnt_q) |-> (gap_q >= 9'(TURN_CYCLES)));
`endif

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Scoreboard bench for gpio_bank_arbiter: per-cycle expectations queued at drive time,
// popped and compared on the falling edge. A second instance covers TURN_CYCLES=1.
module tb_gpio_bank_arbiter;
  localparam int NG     = 64;
  localparam int S_SKIP = -1;
  localparam int S_IDLE = 0;
  localparam int S_OWN0 = 1;
  localparam int S_OWN1 = 2;
  localparam int S_TURN = 3;

  typedef struct packed {
    logic          sel;
    logic [1:0]    gnt;
    logic [1:0]    owner;
    logic          turn;
    logic [NG-1:0] dir;
    logic [NG-1:0] out;
    logic [NG-1:0] r0in;
    logic [NG-1:0] r1in;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    req_i;
  logic [NG-1:0] r0_gpio_out_i, r0_gpio_dir_i, r1_gpio_out_i, r1_gpio_dir_i, gpio_in_i;
  logic [NG-1:0] nxt_r0o, nxt_r0d, nxt_r1o, nxt_r1d, nxt_gin;

  logic [1:0]    gnt_o, owner_o;
  logic          turn_o;
  logic [NG-1:0] gpio_out_o, gpio_dir_o, r0_gpio_in_o, r1_gpio_in_o;

  logic [1:0]    b_gnt_o, b_owner_o;
  logic          b_turn_o;
  logic [NG-1:0] b_gpio_out_o, b_gpio_dir_o, b_r0_gpio_in_o, b_r1_gpio_in_o;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   sb_cycle = 0;

  always #5 clk_i = ~clk_i;

  gpio_bank_arbiter #(.NUM_GPIO(NG), .TURN_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .r0_gpio_out_i(r0_gpio_out_i), .r0_gpio_dir_i(r0_gpio_dir_i), .r0_gpio_in_o(r0_gpio_in_o),
    .r1_gpio_out_i(r1_gpio_out_i), .r1_gpio_dir_i(r1_gpio_dir_i), .r1_gpio_in_o(r1_gpio_in_o),
    .gpio_out_o(gpio_out_o), .gpio_dir_o(gpio_dir_o), .gpio_in_i(gpio_in_i),
    .turn_o(turn_o), .owner_o(owner_o)
  );

  gpio_bank_arbiter #(.NUM_GPIO(NG), .TURN_CYCLES(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(b_gnt_o),
    .r0_gpio_out_i(r0_gpio_out_i), .r0_gpio_dir_i(r0_gpio_dir_i), .r0_gpio_in_o(b_r0_gpio_in_o),
    .r1_gpio_out_i(r1_gpio_out_i), .r1_gpio_dir_i(r1_gpio_dir_i), .r1_gpio_in_o(b_r1_gpio_in_o),
    .gpio_out_o(b_gpio_out_o), .gpio_dir_o(b_gpio_dir_o), .gpio_in_i(gpio_in_i),
    .turn_o(b_turn_o), .owner_o(b_owner_o)
  );

  task automatic check(input string tag, input logic [NG-1:0] obs, input logic [NG-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, sb_cycle, obs, exp);
    end
  endtask

  function automatic logic [NG-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_data(input logic [NG-1:0] r0o, input logic [NG-1:0] r0d,
                          input logic [NG-1:0] r1o, input logic [NG-1:0] r1d,
                          input logic [NG-1:0] gin);
    nxt_r0o = r0o; nxt_r0d = r0d; nxt_r1o = r1o; nxt_r1d = r1d; nxt_gin = gin;
  endtask

  task automatic push_exp(input int st, input bit sel);
    exp_t x;
    x = '0;
    x.sel = sel;
    case (st)
      S_OWN0: begin
        x.gnt = 2'b01; x.owner = 2'b01;
        x.dir = r0_gpio_dir_i; x.out = r0_gpio_out_i; x.r0in = gpio_in_i;
      end
      S_OWN1: begin
        x.gnt = 2'b10; x.owner = 2'b10;
        x.dir = r1_gpio_dir_i; x.out = r1_gpio_out_i; x.r1in = gpio_in_i;
      end
      S_TURN:  x.turn = 1'b1;
      default: ;
    endcase
    exp_q.push_back(x);
  endtask

  // One cycle: advance past the edge, apply this cycle's inputs, queue the expected outputs.
  task automatic cyc(input logic r, input logic [1:0] rq, input int st, input bit sel, input bit rnd);
    @(posedge clk_i);
    #1;
    if (rnd) set_data(rand64(), rand64(), rand64(), rand64(), rand64());
    rst_i = r;
    req_i = rq;
    r0_gpio_out_i = nxt_r0o; r0_gpio_dir_i = nxt_r0d;
    r1_gpio_out_i = nxt_r1o; r1_gpio_dir_i = nxt_r1d;
    gpio_in_i     = nxt_gin;
    if (st != S_SKIP) push_exp(st, sel);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      sb_cycle++;
      if (!e.sel) begin
        check("gnt",   NG'(gnt_o),   NG'(e.gnt));
        check("owner", NG'(owner_o), NG'(e.owner));
        check("turn",  NG'(turn_o),  NG'(e.turn));
        check("dir",   gpio_dir_o,   e.dir);
        check("out",   gpio_out_o,   e.out);
        check("r0in",  r0_gpio_in_o, e.r0in);
        check("r1in",  r1_gpio_in_o, e.r1in);
      end else begin
        check("t1_gnt",   NG'(b_gnt_o),   NG'(e.gnt));
        check("t1_owner", NG'(b_owner_o), NG'(e.owner));
        check("t1_turn",  NG'(b_turn_o),  NG'(e.turn));
        check("t1_dir",   b_gpio_dir_o,   e.dir);
        check("t1_out",   b_gpio_out_o,   e.out);
        check("t1_r0in",  b_r0_gpio_in_o, e.r0in);
        check("t1_r1in",  b_r1_gpio_in_o, e.r1in);
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    req_i = 2'b00;
    set_data('0, '0, '0, '0, '0);
    r0_gpio_out_i = '0; r0_gpio_dir_i = '0; r1_gpio_out_i = '0; r1_gpio_dir_i = '0; gpio_in_i = '0;

    // Reset values, then single requester 0 with fixed pad values.
    cyc(1, 2'b00, S_IDLE, 0, 1);
    cyc(1, 2'b00, S_IDLE, 0, 1);
    set_data(64'hA5, 64'hFF, 64'h0, 64'h0, 64'h3C);
    cyc(0, 2'b01, S_IDLE, 0, 0);
    cyc(0, 2'b01, S_OWN0, 0, 0);
    repeat (3) cyc(0, 2'b01, S_OWN0, 0, 1);
    cyc(0, 2'b00, S_OWN0, 0, 1);
    repeat (4) cyc(0, 2'b00, S_TURN, 0, 1);
    cyc(0, 2'b00, S_IDLE, 0, 1);

    // Both requesting from reset: requester 0 first, then handover after a 4-cycle turn.
    cyc(1, 2'b11, S_IDLE, 0, 1);
    cyc(0, 2'b11, S_IDLE, 0, 1);
    repeat (3) cyc(0, 2'b11, S_OWN0, 0, 1);
    cyc(0, 2'b10, S_OWN0, 0, 1);
    repeat (4) cyc(0, 2'b10, S_TURN, 0, 1);
    cyc(0, 2'b10, S_OWN1, 0, 1);

    // Owner drops while the other raises; then no preemption over 100 cycles.
    cyc(0, 2'b01, S_OWN1, 0, 1);
    repeat (4) cyc(0, 2'b01, S_TURN, 0, 1);
    repeat (100) cyc(0, 2'b11, S_OWN0, 0, 1);
    cyc(0, 2'b10, S_OWN0, 0, 1);
    repeat (4) cyc(0, 2'b10, S_TURN, 0, 1);
    cyc(0, 2'b10, S_OWN1, 0, 1);

    // Owner 1 re-raises during turn while requester 0 waits: requester 0 wins.
    cyc(0, 2'b01, S_OWN1, 0, 1);
    cyc(0, 2'b01, S_TURN, 0, 1);
    repeat (3) cyc(0, 2'b11, S_TURN, 0, 1);
    cyc(0, 2'b11, S_OWN0, 0, 1);

    // Reset while requester 1 drives all pads.
    cyc(0, 2'b10, S_OWN0, 0, 1);
    repeat (4) cyc(0, 2'b10, S_TURN, 0, 1);
    set_data(rand64(), rand64(), rand64(), '1, rand64());
    cyc(0, 2'b10, S_OWN1, 0, 0);
    cyc(1, 2'b10, S_OWN1, 0, 0);
    cyc(0, 2'b11, S_IDLE, 0, 0);
    cyc(0, 2'b11, S_OWN0, 0, 1);

    // TURN_CYCLES=1 instance: single tristate cycle and direct regrant.
    cyc(1, 2'b00, S_SKIP, 1, 1);
    cyc(0, 2'b01, S_IDLE, 1, 1);
    cyc(0, 2'b01, S_OWN0, 1, 1);
    cyc(0, 2'b00, S_OWN0, 1, 1);
    cyc(0, 2'b01, S_TURN, 1, 1);
    repeat (2) cyc(0, 2'b01, S_OWN0, 1, 1);
    cyc(0, 2'b00, S_OWN0, 1, 1);
    cyc(0, 2'b00, S_TURN, 1, 1);
    cyc(0, 2'b00, S_IDLE, 1, 1);

    @(negedge clk_i);
    #1;
    check("sb_drain", NG'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
